wb_peripheral_bus_bridge: RTL and testbench
===========================================

# wb_peripheral_bus_bridge

Wishbone-classic slave to peripheral-bus initiator. Sits between the core/management Wishbone interconnect and the shared peripheral bus that the GPIO, UART, SPI and other peripherals respond on. It converts one Wishbone cycle into one peripheral-bus access, honours `peripheralBus_busy` wait states, and returns read data or all-ones when no peripheral claims the access. One transaction is in flight at a time.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: busy cycles tolerated before abort; only used with the timeout feature, range 1..65535.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `wb_cyc_i`  in  1  Wishbone cycle
- `wb_stb_i`  in  1  Wishbone strobe
- `wb_we_i`  in  1  1 = write
- `wb_sel_i`  in  4  byte lanes
- `wb_adr_i`  in  32  byte address; bits [23:0] forwarded, [31:24] ignored (decoded upstream)
- `wb_data_i`  in  32  write data
- `wb_ack_o`  out  1  transfer done, one-cycle pulse
- `wb_err_o`  out  1  transfer aborted by timeout, one-cycle pulse
- `wb_data_o`  out  32  read data, valid while `wb_ack_o` is high
- `peripheralBus_we`  out  1  write strobe
- `peripheralBus_oe`  out  1  read strobe
- `peripheralBus_address`  out  24  access address
- `peripheralBus_byteSelect`  out  4  byte lanes
- `peripheralBus_dataWrite`  out  32  write data
- `peripheralBus_busy`  in  1  responder wait request
- `peripheralBus_dataRead`  in  32  responder read data
- `requestOutput`  in  1  some responder claims the read

## Operation
- States: IDLE, ACCESS, ACK.
- IDLE: if `wb_cyc_i & wb_stb_i`, register address[23:0], sel, data and we, then go to ACCESS. Assert `peripheralBus_we` (if we) or `peripheralBus_oe` (if not). The two strobes are never both asserted.
- ACCESS: strobes and address are held stable.
  - `peripheralBus_busy` = 1: stay in ACCESS.
  - `peripheralBus_busy` = 0: on a read, capture `peripheralBus_dataRead` if `requestOutput` = 1, else capture 32'hFFFF_FFFF. Drop both strobes and go to ACK. Writes capture nothing.
- ACK: pulse `wb_ack_o` for one cycle, then go to IDLE. A `wb_stb_i` seen during ACK is not taken as a new request.
- `wb_cyc_i` falling while in ACCESS: drop both strobes, return to IDLE, no ack or err.
- Reset asserted in any state: state = IDLE. All outputs become 0 immediately; this includes the bus address, byteSelect, dataWrite and `wb_data_o`.
- `wb_data_o` holds its last captured value until the next read capture.

## Timing
- Registered outputs only; no combinational path from the Wishbone inputs to the bus outputs.
- With zero wait states: stb sampled at edge 0, strobes high after edge 0, bus sampled not-busy at edge 1, ack high after edge 1, ack low after edge 2. This gives 2-cycle request-to-ack latency and a minimum of 3 cycles per transaction including ACK.
- Each busy cycle adds exactly one cycle of latency.
- Back-to-back: the next request is accepted in the first IDLE cycle after ACK.

## Configuration
- `PERIPHERAL_BUS_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to ACCESS and increments on each busy cycle.
  - When the count reaches `TIMEOUT_CYCLES` while busy is still high: drop the strobes, go to ACK, and pulse `wb_err_o` instead of `wb_ack_o`. Read data captured is 32'hFFFF_FFFF.
  - If busy falls on the same cycle the count reaches the limit, the access completes normally.
- Not defined: no counter and `wb_err_o` tied to 0. ACCESS waits indefinitely.

## Structure
- Shared package `peripheral_bus_pkg` holds:
  - the state enum (IDLE/ACCESS/ACK)
  - `PERIPHERAL_ADDR_W` = 24 and `PERIPHERAL_DATA_W` = 32
  - `PERIPHERAL_UNCLAIMED_DATA` = 32'hFFFF_FFFF
  
  Responders reuse the same package.
- One sub-module, `peripheral_bus_timeout`, holds the counter and compare. It is instantiated only under `PERIPHERAL_BUS_TIMEOUT_EN`.

## Test plan
- Write with wb_adr 0x0003_0010, sel 0xF, data 0xA5A5_1234, busy 0: strobe `peripheralBus_we` for 1 cycle with address 0x03_0010 and the same data, then `wb_ack_o` one cycle later; `peripheralBus_oe` stays 0.
- Read with a responder driving 0xDEAD_BEEF and requestOutput 1: `wb_data_o` = 0xDEAD_BEEF with ack, 2 cycles after stb.
- Read with busy held for 3 cycles: `peripheralBus_oe` held for 4 cycles, ack 5 cycles after stb, address stable throughout.
- Read with requestOutput 0: `wb_data_o` = 0xFFFF_FFFF with ack, err 0.
- With `PERIPHERAL_BUS_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 4 and busy stuck at 1: `wb_err_o` pulses once, strobes drop, ack never asserts, and the next transaction completes normally.
- `wb_cyc_i` dropped in ACCESS, and separately `rst` asserted low mid-read: strobes low the same or next cycle, no ack, state IDLE, and all outputs 0 under reset.

Source files
------------

// File: rtl/peripheral_bus_pkg.sv
// Shared peripheral-bus definitions: bridge state encoding, bus widths and the
// data value returned when no responder claims a read.
package peripheral_bus_pkg;

    localparam int unsigned PERIPHERAL_ADDR_W = 24;
    localparam int unsigned PERIPHERAL_DATA_W = 32;
    localparam int unsigned PERIPHERAL_SEL_W  = 4;
    localparam int unsigned TIMEOUT_CNT_W     = 16;

    localparam logic [PERIPHERAL_DATA_W-1:0] PERIPHERAL_UNCLAIMED_DATA = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } bridge_state_e;

    // One latched peripheral-bus request
    typedef struct packed {
        logic                         we;
        logic [PERIPHERAL_SEL_W-1:0]  sel;
        logic [PERIPHERAL_ADDR_W-1:0] addr;
        logic [PERIPHERAL_DATA_W-1:0] data;
    } periph_req_t;

endpackage

// File: rtl/peripheral_bus_timeout.sv
// Busy-cycle counter for the bridge; flags an access that stays busy for
// TIMEOUT_CYCLES counted cycles and is still busy afterwards.
module peripheral_bus_timeout
    import peripheral_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic in_access,
    input  logic busy,
    output logic expired_c
);

    localparam logic [TIMEOUT_CNT_W-1:0] LIMIT = TIMEOUT_CNT_W'(TIMEOUT_CYCLES);

    logic [TIMEOUT_CNT_W-1:0] count_q;

    // Held at zero outside ACCESS, so every access starts from a cleared count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (!in_access) begin
            count_q <= '0;
        end else if (busy && (count_q != LIMIT)) begin
            count_q <= count_q + TIMEOUT_CNT_W'(1);
        end
    end

    assign expired_c = in_access && busy && (count_q == LIMIT);

endmodule

// File: rtl/wb_peripheral_bus_bridge.sv
// Wishbone-classic slave to peripheral-bus initiator, one access in flight.
// Optional busy timeout with wb_err_o is built when PERIPHERAL_BUS_TIMEOUT_EN is defined.
module wb_peripheral_bus_bridge
    import peripheral_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wb_cyc_i,
    input  logic                         wb_stb_i,
    input  logic                         wb_we_i,
    input  logic [PERIPHERAL_SEL_W-1:0]  wb_sel_i,
    input  logic [31:0]                  wb_adr_i,
    input  logic [PERIPHERAL_DATA_W-1:0] wb_data_i,
    output logic                         wb_ack_o,
    output logic                         wb_err_o,
    output logic [PERIPHERAL_DATA_W-1:0] wb_data_o,
    output logic                         peripheralBus_we,
    output logic                         peripheralBus_oe,
    output logic [PERIPHERAL_ADDR_W-1:0] peripheralBus_address,
    output logic [PERIPHERAL_SEL_W-1:0]  peripheralBus_byteSelect,
    output logic [PERIPHERAL_DATA_W-1:0] peripheralBus_dataWrite,
    input  logic                         peripheralBus_busy,
    input  logic [PERIPHERAL_DATA_W-1:0] peripheralBus_dataRead,
    input  logic                         requestOutput
);

    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("wb_peripheral_bus_bridge: TIMEOUT_CYCLES must be in 1..65535");
    end

    bridge_state_e                state_q, state_d;
    periph_req_t                  req_q, req_d;
    logic                         we_q, we_d;
    logic                         oe_q, oe_d;
    logic                         ack_q, ack_d;
    logic                         err_q, err_d;
    logic [PERIPHERAL_DATA_W-1:0] rdata_q, rdata_d;
    logic                         timeout_c;

    // Upper address byte is decoded by the interconnect
    logic unused_adr_hi;
    assign unused_adr_hi = &{1'b0, wb_adr_i[31:24]};

`ifdef PERIPHERAL_BUS_TIMEOUT_EN
    peripheral_bus_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .in_access (state_q == ACCESS),
        .busy      (peripheralBus_busy),
        .expired_c (timeout_c)
    );
`else
    assign timeout_c = 1'b0;
`endif

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            req_q   <= '0;
            we_q    <= 1'b0;
            oe_q    <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            oe_q    <= oe_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Next state and next register values
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        oe_d    = oe_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    req_d.we   = wb_we_i;
                    req_d.sel  = wb_sel_i;
                    req_d.addr = wb_adr_i[PERIPHERAL_ADDR_W-1:0];
                    req_d.data = wb_data_i;
                    we_d       = wb_we_i;
                    oe_d       = !wb_we_i;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                if (!wb_cyc_i) begin
                    // Master abandoned the cycle: release the bus silently
                    we_d    = 1'b0;
                    oe_d    = 1'b0;
                    state_d = IDLE;
                end else if (timeout_c) begin
                    we_d    = 1'b0;
                    oe_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = ACK;
                    if (!req_q.we) begin
                        rdata_d = PERIPHERAL_UNCLAIMED_DATA;
                    end
                end else if (!peripheralBus_busy) begin
                    we_d    = 1'b0;
                    oe_d    = 1'b0;
                    ack_d   = 1'b1;
                    state_d = ACK;
                    if (!req_q.we) begin
                        rdata_d = requestOutput ? peripheralBus_dataRead
                                                : PERIPHERAL_UNCLAIMED_DATA;
                    end
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign wb_ack_o                 = ack_q;
    assign wb_err_o                 = err_q;
    assign wb_data_o                = rdata_q;
    assign peripheralBus_we         = we_q;
    assign peripheralBus_oe         = oe_q;
    assign peripheralBus_address    = req_q.addr;
    assign peripheralBus_byteSelect = req_q.sel;
    assign peripheralBus_dataWrite  = req_q.data;

endmodule

// File: tb/tb_wb_peripheral_bus_bridge.sv
// Randomised scoreboard bench for wb_peripheral_bus_bridge; the timeout scenario
// runs only when PERIPHERAL_BUS_TIMEOUT_EN is defined.
module tb_wb_peripheral_bus_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdata;
    logic        ack, err;
    logic [31:0] rdata_o;
    logic        pb_we, pb_oe;
    logic [23:0] pb_addr;
    logic [3:0]  pb_sel;
    logic [31:0] pb_wdata;
    logic        busy;
    logic [31:0] pb_rdata;
    logic        req_out;

    always #5 clk = ~clk;

    wb_peripheral_bus_bridge #(.TIMEOUT_CYCLES(4)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .wb_cyc_i                 (cyc),
        .wb_stb_i                 (stb),
        .wb_we_i                  (we),
        .wb_sel_i                 (sel),
        .wb_adr_i                 (adr),
        .wb_data_i                (wdata),
        .wb_ack_o                 (ack),
        .wb_err_o                 (err),
        .wb_data_o                (rdata_o),
        .peripheralBus_we         (pb_we),
        .peripheralBus_oe         (pb_oe),
        .peripheralBus_address    (pb_addr),
        .peripheralBus_byteSelect (pb_sel),
        .peripheralBus_dataWrite  (pb_wdata),
        .peripheralBus_busy       (busy),
        .peripheralBus_dataRead   (pb_rdata),
        .requestOutput            (req_out)
    );

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          lat;
        int          t_issue;
    } rsp_t;

    typedef struct {
        logic        we;
        logic [23:0] addr;
        logic [3:0]  sel;
        logic [31:0] data;
        int          len;
    } bus_t;

    rsp_t        rsp_q[$];
    bus_t        bus_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc_n = 0;
    int          busy_left = 0;
    logic        strobe_seen = 1'b0;
    logic [31:0] last_read = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc_n <= cyc_n + 1;
    always @(negedge clk) strobe_seen <= pb_we | pb_oe;

    // Responder: holds busy for the requested number of sampled cycles
    initial forever begin
        @(posedge clk);
        #1;
        if (strobe_seen && busy_left > 0) begin
            busy_left--;
            busy = (busy_left != 0);
        end
    end

    // Monitor: pops expectations whenever the DUT shows a strobe or a response
    initial begin : monitor
        logic prev_s, prev_rsp, s, have_cur;
        bus_t cur;
        rsp_t r;
        int   len_cnt;
        prev_s = 1'b0; prev_rsp = 1'b0; have_cur = 1'b0; len_cnt = 0;
        forever begin
            @(negedge clk);
            s = pb_we | pb_oe;
            if (s) chk("strobe_exclusive", 32'(pb_we & pb_oe), 32'h0);
            if (s && !prev_s) begin
                if (bus_q.size() == 0) begin
                    chk("unexpected_strobe", 32'(s), 32'h0);
                end else begin
                    cur = bus_q.pop_front();
                    have_cur = 1'b1;
                    len_cnt = 1;
                    chk("bus_we", 32'(pb_we), 32'(cur.we));
                    chk("bus_oe", 32'(pb_oe), 32'(!cur.we));
                    chk("bus_addr", 32'(pb_addr), 32'(cur.addr));
                    chk("bus_sel", 32'(pb_sel), 32'(cur.sel));
                    if (cur.we) chk("bus_wdata", pb_wdata, cur.data);
                end
            end else if (s && prev_s) begin
                len_cnt++;
                if (have_cur) chk("addr_stable", 32'(pb_addr), 32'(cur.addr));
            end else if (!s && prev_s && have_cur) begin
                if (cur.len >= 0) chk("strobe_len", 32'(len_cnt), 32'(cur.len));
                have_cur = 1'b0;
            end
            prev_s = s;

            if (ack || err) begin
                if (prev_rsp) chk("rsp_one_cycle", 32'({ack, err}), 32'h0);
                if (rsp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'({ack, err}), 32'h0);
                end else begin
                    r = rsp_q.pop_front();
                    chk("rsp_ack", 32'(ack), 32'(!r.err));
                    chk("rsp_err", 32'(err), 32'(r.err));
                    chk("rsp_data", rdata_o, r.data);
                    if (r.lat >= 0) chk("rsp_latency", 32'(cyc_n - r.t_issue), 32'(r.lat));
                end
            end
            prev_rsp = ack | err;
        end
    end

    // mode 0: normal, 1: cyc will be dropped (no response), 2: timeout expected,
    // 3: reset will be applied mid-access (no response, length unknown)
    task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] wd, input logic [31:0] rd, input logic claim,
                         input int nbusy, input int mode);
        bus_t b;
        rsp_t r;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdata = wd;
        pb_rdata = rd; req_out = claim;
        busy_left = nbusy; busy = (nbusy > 0);
        b.we = w; b.addr = a[23:0]; b.sel = s; b.data = wd;
        b.len = (mode == 0) ? nbusy + 1 : (mode == 1) ? 1 : -1;
        bus_q.push_back(b);
        if (mode == 0 || mode == 2) begin
            if (!w) last_read = (mode == 2 || !claim) ? 32'hFFFF_FFFF : rd;
            r.err = (mode == 2);
            r.data = last_read;
            r.lat = (mode == 0) ? nbusy + 2 : -1;
            r.t_issue = cyc_n;
            rsp_q.push_back(r);
        end
    endtask

    task automatic wait_rsp();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (ack || err) break;
        end
        chk("rsp_seen", 32'(ack | err), 32'h1);
        @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic txn(input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] wd, input logic [31:0] rd, input logic claim,
                       input int nbusy);
        issue(w, a, s, wd, rd, claim, nbusy, 0);
        wait_rsp();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ack"}, 32'(ack), 32'h0);
        chk({tag, "_err"}, 32'(err), 32'h0);
        chk({tag, "_rdata"}, rdata_o, 32'h0);
        chk({tag, "_strobes"}, 32'({pb_we, pb_oe}), 32'h0);
        chk({tag, "_addr"}, 32'(pb_addr), 32'h0);
        chk({tag, "_sel"}, 32'(pb_sel), 32'h0);
        chk({tag, "_wdata"}, pb_wdata, 32'h0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; wdata = '0;
        busy = 1'b0; pb_rdata = '0; req_out = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        txn(1'b1, 32'h0003_0010, 4'hF, 32'hA5A5_1234, 32'h0, 1'b0, 0);
        txn(1'b0, 32'h0100_0200, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b1, 0);
        txn(1'b0, 32'h0000_0ABC, 4'h3, 32'h0, 32'h1234_5678, 1'b1, 3);
        txn(1'b0, 32'h00FF_FFFC, 4'hF, 32'h0, 32'h5555_AAAA, 1'b0, 0);
        txn(1'b1, 32'hFF12_3456, 4'h1, 32'h0BAD_F00D, 32'h0, 1'b0, 1);

        // Randomised traffic, including back-to-back requests (gap 0)
        for (int n = 0; n < 40; n++) begin
            int gap;
            txn(1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom, $urandom,
                1'($urandom_range(0, 3) != 0), $urandom_range(0, 3));
            gap = $urandom_range(0, 2);
            repeat (gap) begin @(posedge clk); #1; end
        end

        // Master drops cyc while the access is busy
        issue(1'b0, 32'h0004_4444, 4'hF, 32'h0, 32'h7777_7777, 1'b1, 3, 1);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        chk("abort_strobes_low", 32'({pb_we, pb_oe}), 32'h0);
        repeat (4) @(posedge clk);
        #1;
        chk("abort_no_rsp_pending", 32'(rsp_q.size()), 32'h0);
        busy_left = 0; busy = 1'b0;
        txn(1'b0, 32'h0000_1000, 4'hF, 32'h0, 32'hCAFE_0001, 1'b1, 0);

        // Reset asserted in the middle of a busy read
        issue(1'b0, 32'h0008_8888, 4'hC, 32'h0, 32'h9999_0000, 1'b1, 3, 3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check_all_zero("midreset");
        busy_left = 0; busy = 1'b0; cyc = 1'b0; stb = 1'b0;
        last_read = 32'h0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        txn(1'b1, 32'h0000_2000, 4'h6, 32'h1357_9BDF, 32'h0, 1'b0, 0);
        txn(1'b0, 32'h0000_2004, 4'hF, 32'h0, 32'h2468_ACE0, 1'b1, 2);

`ifdef PERIPHERAL_BUS_TIMEOUT_EN
        // Responder stuck busy: err instead of ack, then normal traffic resumes
        issue(1'b0, 32'h000B_0000, 4'hF, 32'h0, 32'h1111_2222, 1'b1, 1000, 2);
        wait_rsp();
        chk("timeout_strobes_low", 32'({pb_we, pb_oe}), 32'h0);
        busy_left = 0; busy = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        txn(1'b0, 32'h000B_0004, 4'hF, 32'h0, 32'h3333_4444, 1'b1, 1);
`endif

        repeat (4) @(posedge clk);
        #1;
        chk("queues_drained", 32'(rsp_q.size() + bus_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
